// File: rtl/multdiv_issue.sv
// Issue/stall controller between the DX stage and the shared multiply/divide unit.
// Pulses the unit once, stalls until the result (or a timeout), then writes back for one cycle.
module multdiv_issue #(
  parameter int unsigned RSTATUS_REG   = 30,
  parameter int unsigned MULT_EXC_CODE = 4,
  parameter int unsigned DIV_EXC_CODE  = 5,
  parameter int unsigned TIMEOUT       = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dx_is_mult,
  input  logic        dx_is_div,
  input  logic [4:0]  dx_rd,
  input  logic [31:0] dx_opA,
  input  logic [31:0] dx_opB,
  input  logic        flush,
  input  logic [31:0] md_result,
  input  logic        md_resultRDY,
  input  logic        md_exception,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] data_operandA,
  output logic [31:0] data_operandB,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        timeout_err
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic               op_div_q, op_div_d;
  logic [REG_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]  opa_q, opa_d;
  logic [DATA_W-1:0]  opb_q, opb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               exc_q, exc_d;
  logic               timeout_q, timeout_d;
  logic               request;

  assign request = dx_is_mult | dx_is_div;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_div_q  <= 1'b0;
      rd_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      exc_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_div_q  <= op_div_d;
      rd_q      <= rd_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state: flush wins over a result arriving in the same WAIT cycle.
  always_comb begin
    state_d   = state_q;
    op_div_d  = op_div_q;
    rd_d      = rd_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    exc_d     = exc_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (request && !flush) begin
          op_div_d = dx_is_div;
          rd_d     = dx_rd;
          opa_d    = dx_opA;
          opb_d    = dx_opB;
          exc_d    = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = flush ? IDLE : WAIT;
      end
      WAIT: begin
        if (flush) begin
          state_d = IDLE;
        end else if (md_resultRDY) begin
          result_d = md_result;
          exc_d    = md_exception;
          state_d  = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          exc_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the registered state; only the accept-cycle stall looks at live inputs.
  always_comb begin
    ctrl_MULT     = (state_q == START) && !op_div_q;
    ctrl_DIV      = (state_q == START) && op_div_q;
    data_operandA = opa_q;
    data_operandB = opb_q;
    stall         = !reset && (((state_q == IDLE) && request && !flush) ||
                               (state_q == START) || (state_q == WAIT));
    wb_valid      = (state_q == DONE);
    wb_rd         = '0;
    wb_data       = '0;
    timeout_err   = timeout_q;
    if (state_q == DONE) begin
      if (exc_q) begin
        wb_rd   = REG_W'(RSTATUS_REG);
        wb_data = op_div_q ? DATA_W'(DIV_EXC_CODE) : DATA_W'(MULT_EXC_CODE);
      end else begin
        wb_rd   = rd_q;
        wb_data = result_q;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed bench for multdiv_issue: table of full ops plus flush, timeout and async-reset sequences.
module tb_multdiv_issue;

  logic        clock = 1'b0;
  logic        reset;
  logic        dx_is_mult, dx_is_div;
  logic [4:0]  dx_rd;
  logic [31:0] dx_opA, dx_opB;
  logic        flush;
  logic [31:0] md_result;
  logic        md_resultRDY, md_exception;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic        stall, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        timeout_err;

  multdiv_issue dut (
    .clock(clock), .reset(reset),
    .dx_is_mult(dx_is_mult), .dx_is_div(dx_is_div), .dx_rd(dx_rd),
    .dx_opA(dx_opA), .dx_opB(dx_opB), .flush(flush),
    .md_result(md_result), .md_resultRDY(md_resultRDY), .md_exception(md_exception),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_div;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    logic        exc;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;
  int viol     = 0;
  logic prev_ctrl = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Start pulses must be single-cycle, exclusive and never adjacent.
  always @(negedge clock) begin
    if (ctrl_MULT && ctrl_DIV) viol++;
    if ((ctrl_MULT || ctrl_DIV) && prev_ctrl) viol++;
    if (ctrl_MULT || ctrl_DIV) pulses++;
    prev_ctrl = ctrl_MULT || ctrl_DIV;
  end

  // Called #1 after a posedge with the DUT idle; returns #1 after the edge that enters START.
  task automatic issue(input logic is_div, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b);
    bit seen = 0;
    dx_is_mult = !is_div;
    dx_is_div  = is_div;
    dx_rd  = rd;
    dx_opA = a;
    dx_opB = b;
    #1;
    chk("stall_accept", 32'(stall), 32'd1);
    for (int i = 0; i < 4 && !seen; i++) begin
      @(posedge clock); #1;
      if (ctrl_MULT || ctrl_DIV) seen = 1;
    end
    chk("ctrl_seen", 32'(seen), 32'd1);
    chk("ctrl_mult", 32'(ctrl_MULT), 32'(!is_div));
    chk("ctrl_div", 32'(ctrl_DIV), 32'(is_div));
    chk("opA_at_pulse", data_operandA, a);
    chk("opB_at_pulse", data_operandB, b);
  endtask

  task automatic run_op(input vec_t v);
    bit held = 1;
    issue(v.is_div, v.rd, v.a, v.b);
    for (int i = 1; i <= v.lat; i++) begin
      @(posedge clock); #1;
      if (data_operandA !== v.a || data_operandB !== v.b || stall !== 1'b1 ||
          ctrl_MULT || ctrl_DIV || wb_valid) held = 0;
      if (i == v.lat) begin
        md_resultRDY = 1'b1;
        md_result    = v.res;
        md_exception = v.exc;
      end
    end
    chk("wait_held", 32'(held), 32'd1);
    @(posedge clock); #1;
    md_resultRDY = 1'b0;
    md_exception = 1'b0;
    dx_is_mult = 1'b0;
    dx_is_div  = 1'b0;
    chk("wb_valid", 32'(wb_valid), 32'd1);
    chk("wb_rd", 32'(wb_rd), 32'(v.exp_rd));
    chk("wb_data", wb_data, v.exp_data);
    chk("stall_done", 32'(stall), 32'd0);
    @(posedge clock); #1;
    chk("wb_valid_after", 32'(wb_valid), 32'd0);
    chk("wb_data_after", wb_data, 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    bit quiet;
    vecs[0] = '{1'b0, 5'd5,  32'd6,          32'd7,          32'd42,         17, 1'b0, 5'd5,  32'd42};
    vecs[1] = '{1'b1, 5'd9,  32'hFFFFFFEC,   32'd3,          32'hFFFFFFFA,   20, 1'b0, 5'd9,  32'hFFFFFFFA};
    vecs[2] = '{1'b1, 5'd12, 32'd77,         32'd0,          32'd0,          36, 1'b1, 5'd30, 32'd5};
    vecs[3] = '{1'b0, 5'd4,  32'h40000000,   32'd4,          32'd0,          10, 1'b1, 5'd30, 32'd4};
    vecs[4] = '{1'b0, 5'd31, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,           1, 1'b0, 5'd31, 32'd1};

    reset = 1'b1;
    dx_is_mult = 0; dx_is_div = 0; dx_rd = '0; dx_opA = '0; dx_opB = '0;
    flush = 0; md_result = '0; md_resultRDY = 0; md_exception = 0;
    #12;
    chk("rst_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_wb", 32'({wb_valid, wb_rd}), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;

    for (int k = 0; k < 5; k++) run_op(vecs[k]);

    // Flush at WAIT cycle 10, then a late result that must be ignored.
    issue(1'b0, 5'd8, 32'd100, 32'd200);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clock); #1;
      if (i == 10) begin flush = 1'b1; dx_is_mult = 1'b0; end
    end
    @(posedge clock); #1;
    flush = 1'b0;
    chk("flush_stall", 32'(stall), 32'd0);
    chk("flush_wb", 32'(wb_valid), 32'd0);
    quiet = 1;
    for (int i = 0; i < 4; i++) begin
      md_resultRDY = (i == 1);
      md_result    = 32'hDEAD;
      @(posedge clock); #1;
      if (wb_valid || stall) quiet = 0;
    end
    md_resultRDY = 1'b0;
    chk("late_rdy_ignored", 32'(quiet), 32'd1);
    run_op('{1'b0, 5'd2, 32'd3, 32'd4, 32'd12, 6, 1'b0, 5'd2, 32'd12});

    // Unit never answers: forced abort after 40 WAIT cycles.
    issue(1'b1, 5'd7, 32'd100, 32'd0);
    n = 0;
    while (n < 60 && !wb_valid) begin
      @(posedge clock); #1;
      n++;
    end
    dx_is_div = 1'b0;
    chk("timeout_latency", 32'(n), 32'd41);
    chk("timeout_wb_rd", 32'(wb_rd), 32'd30);
    chk("timeout_wb_data", wb_data, 32'd5);
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    @(posedge clock); #1;
    chk("timeout_err_sticky", 32'(timeout_err), 32'd1);

    // Async reset mid-WAIT, off the clock edge.
    issue(1'b0, 5'd3, 32'd11, 32'd13);
    for (int i = 0; i < 5; i++) begin @(posedge clock); #1; end
    #2;
    dx_is_mult = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_opA", data_operandA, 32'd0);
    chk("arst_opB", data_operandB, 32'd0);
    chk("arst_wb", 32'({wb_valid, wb_rd}), 32'd0);
    chk("arst_wb_data", wb_data, 32'd0);
    chk("arst_timeout_clr", 32'(timeout_err), 32'd0);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    chk("post_rst_idle", 32'(stall), 32'd0);
    run_op('{1'b0, 5'd3, 32'd11, 32'd13, 32'd143, 5, 1'b0, 5'd3, 32'd143});

    chk("ctrl_violations", 32'(viol), 32'd0);
    chk("ctrl_pulse_count", 32'(pulses), 32'd10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
